// File: rtl/run_ctrl.sv
// run_ctrl: run-control responder for the CPU Start/Ack launch handshake.
//
// Holds the PC in init while Start is high, releases execution when Start
// falls, counts RUN cycles and raises Ack once the decoder flags a halt.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous reset, active low
//   Start    in   launch request (high = load/hold, falling = begin program)
//   Halt     in   decoder flag: current instruction is the halt opcode
//   Ack      out  program run complete (registered)
//   PcInit   out  force PC to its start address
//   PcEn     out  enable PC advance / architectural writes
//   Busy     out  high while in RUN
//   CycleCt  out  RUN cycles of the current or last program (saturating)
//   Timeout  out  watchdog fired (0 unless RUN_WATCHDOG_EN is defined)
//
// Build option: define RUN_WATCHDOG_EN to end a run after MAX_CYCLES RUN
// cycles without a halt; Timeout flags that case.
module run_ctrl #(
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 32'hFFF0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          Ack,
  output logic          PcInit,
  output logic          PcEn,
  output logic          Busy,
  output logic [CW-1:0] CycleCt,
  output logic          Timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          ack_q;
  logic [CW-1:0] cnt_q;
  logic          wd_hit;   // watchdog limit reached this RUN cycle
  logic          wd_fire;  // RUN -> DONE caused by the watchdog

`ifdef RUN_WATCHDOG_EN
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);
  assign wd_hit = (cnt_q == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    PcInit  = 1'b1;
    PcEn    = 1'b0;
    Busy    = 1'b0;
    wd_fire = 1'b0;
    case (state_q)
      IDLE:  if (Start) state_d = ARMED;
      ARMED: if (!Start) state_d = RUN;
      RUN: begin
        PcInit = 1'b0;
        Busy   = 1'b1;
        // the halt instruction itself must not advance the PC
        PcEn   = ~Halt;
        // abort beats halt, halt beats watchdog
        if (Start)       state_d = ARMED;
        else if (Halt)   state_d = DONE;
        else if (wd_hit) begin
          state_d = DONE;
          wd_fire = 1'b1;
        end
      end
      DONE: begin
        PcInit = 1'b0;
        if (Start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Ack is the DONE decode, registered alongside the state
      ack_q   <= (state_d == DONE);
      if (state_q == ARMED)
        cnt_q <= '0;
      else if (state_q == RUN && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef RUN_WATCHDOG_EN
  logic to_q;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)               to_q <= 1'b0;
    else if (state_q == ARMED) to_q <= 1'b0;
    else if (wd_fire)          to_q <= 1'b1;
  end
  assign Timeout = to_q;
`else
  logic unused_wd;
  assign unused_wd = wd_hit ^ wd_fire;
  assign Timeout   = 1'b0;
`endif

  assign Ack     = ack_q;
  assign CycleCt = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  localparam int unsigned CW = 8;
`ifdef RUN_WATCHDOG_EN
  localparam int unsigned MAXC = 8;
`else
  localparam int unsigned MAXC = 32'hFFF0;
`endif

  logic          Clk, Reset, Start, Halt;
  logic          Ack, PcInit, PcEn, Busy, Timeout;
  logic [CW-1:0] CycleCt;

  run_ctrl #(.CW(CW), .MAX_CYCLES(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .Ack(Ack), .PcInit(PcInit), .PcEn(PcEn), .Busy(Busy),
    .CycleCt(CycleCt), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {Ack, PcInit, PcEn, Busy, Timeout, CycleCt}
  typedef struct {
    string         name;
    logic [CW+4:0] v;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   stim_done = 0;

  // Drive one cycle's inputs just after the edge and queue what the outputs
  // should look like for the rest of that cycle.
  task automatic cyc(input logic s, h, r, a, pi, pe, bz, input int c,
                     input string nm, input logic to = 1'b0);
    exp_t e;
    @(posedge Clk);
    #1;
    Start = s;
    Halt  = h;
    #1;
    Reset = r;
    e.name = nm;
    e.v    = {a, pi, pe, bz, to, CW'(c)};
    q.push_back(e);
  endtask

  // IDLE / ARMED / reset look
  task automatic pre(input logic s, h, r, input int c, input string nm,
                     input logic to = 1'b0);
    cyc(s, h, r, 1'b0, 1'b1, 1'b0, 1'b0, c, nm, to);
  endtask

  task automatic run(input logic s, h, input int c, input string nm);
    cyc(s, h, 1'b1, 1'b0, 1'b0, ~h, 1'b1, c, nm);
  endtask

  task automatic done(input logic s, h, input int c, input string nm,
                      input logic to = 1'b0);
    cyc(s, h, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c, nm, to);
  endtask

  // monitor: compare on the falling edge, away from the active edge
  initial begin
    exp_t e;
    logic [CW+4:0] got;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {Ack, PcInit, PcEn, Busy, Timeout, CycleCt};
        tests++;
        if (got !== e.v) begin
          fails++;
          $display("FAIL %s: got ack=%b pcinit=%b pcen=%b busy=%b to=%b cyc=%0d, want ack=%b pcinit=%b pcen=%b busy=%b to=%b cyc=%0d",
                   e.name, got[CW+4], got[CW+3], got[CW+2], got[CW+1], got[CW], got[CW-1:0],
                   e.v[CW+4], e.v[CW+3], e.v[CW+2], e.v[CW+1], e.v[CW], e.v[CW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    Reset = 1'b0; Start = 1'b1; Halt = 1'b0;

    // reset held with Start high, then released
    pre(1, 0, 0, 0, "rst0");
    pre(1, 0, 0, 0, "rst1");
    Reset = 1'b1;
    pre(1, 0, 1, 0, "armed0");
    pre(1, 0, 1, 0, "armed1");

    // normal run: halt on the 10th RUN cycle
    pre(0, 0, 1, 0, "armed_rel");
    run(0, 0, 0, "run1");
    for (int k = 2; k <= 9; k++) run(0, 0, k - 1, $sformatf("run%0d", k));
    run(0, 1, 9, "run_halt");
    for (int k = 0; k < 5; k++) done(0, (k == 2), 10, $sformatf("done%0d", k));

    // relaunch from DONE: Start for 3 cycles, halt on the 4th RUN cycle
    done(1, 0, 10, "rl_done");
    pre(1, 0, 1, 10, "rl_armed0");
    pre(1, 0, 1, 0, "rl_armed1");
    pre(0, 0, 1, 0, "rl_armed2");
    run(0, 0, 0, "rl_run1");
    run(0, 0, 1, "rl_run2");
    run(0, 0, 2, "rl_run3");
    run(0, 1, 3, "rl_halt");
    done(0, 0, 4, "rl_done4");

    // abort: Start and Halt together at CycleCt = 6
    done(1, 0, 4, "ab_done");
    pre(1, 0, 1, 4, "ab_armed0");
    pre(0, 0, 1, 0, "ab_armed1");
    run(0, 0, 0, "ab_run1");
    for (int k = 1; k <= 5; k++) run(0, 0, k, $sformatf("ab_run_c%0d", k));
    run(1, 1, 6, "ab_both");
    pre(1, 0, 1, 7, "ab_armed_a");
    pre(1, 0, 1, 0, "ab_armed_b");

    // async reset mid-run at CycleCt = 20
    pre(0, 0, 1, 0, "ar_armed");
    run(0, 0, 0, "ar_run1");
    for (int k = 1; k <= 19; k++) run(0, 0, k, $sformatf("ar_c%0d", k));
    pre(0, 0, 0, 0, "ar_async");
    pre(0, 0, 1, 0, "ar_idle");
    pre(0, 1, 1, 0, "idle_halt");

    // long run with no halt
    pre(1, 0, 1, 0, "wd_idle");
    pre(1, 0, 1, 0, "wd_armed0");
    pre(0, 0, 1, 0, "wd_armed1");
    run(0, 0, 0, "wd_run1");
`ifdef RUN_WATCHDOG_EN
    for (int k = 1; k <= 7; k++) run(0, 0, k, $sformatf("wd_c%0d", k));
    done(0, 0, 8, "wd_fire", 1'b1);
    done(0, 0, 8, "wd_hold", 1'b1);
    done(1, 0, 8, "wd_rl_done", 1'b1);
    pre(1, 0, 1, 8, "wd_rl_armed0", 1'b1);
    pre(1, 0, 1, 0, "wd_rl_armed1", 1'b0);
`else
    for (int k = 1; k <= 300; k++)
      run(0, 0, (k > 255) ? 255 : k, $sformatf("sat_c%0d", k));
`endif

    stim_done = 1;
    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run-control responder for the CPU's Start/Ack launch handshake.
- Receives the Start command from the bench or host and holds the program counter in init while Start is high.
- Releases execution when Start falls, counts execution cycles, and raises Ack when the decoder reports a halt instruction.
- Sits inside the CPU top level, between the external Start/Ack pins and the PC, register-file and instruction-decode enables.

Parameters:
- CW, 16, width of the cycle counter CycleCt.
- MAX_CYCLES, 16'hFFF0, watchdog limit in RUN cycles; used only with RUN_WATCHDOG_EN.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  launch request, level-sensitive; high = load/hold, high-to-low = begin program.
- Halt  input  1  decoder flag: the current instruction is the halt opcode.
- Ack  output  1  program run complete; registered.
- PcInit  output  1  forces the PC to its start address.
- PcEn  output  1  enables PC advance and architectural state writes.
- Busy  output  1  high while in RUN.
- CycleCt  output  CW  count of RUN cycles for the current or last program.
- Timeout  output  1  watchdog fired; tied 0 when the feature is excluded.

Behaviour:
- States are IDLE, ARMED, RUN and DONE, held in a 2-bit state register.
- Reset low, asynchronously and at any time including mid-RUN:
  - state = IDLE, CycleCt = 0, Ack = 0, Timeout = 0.
  - Outputs decode immediately to PcInit = 1, PcEn = 0, Busy = 0.
- IDLE:
  - Outputs: PcInit = 1, PcEn = 0, Ack = 0.
  - Start = 1 moves to ARMED on the next edge.
- ARMED:
  - Outputs: PcInit = 1, PcEn = 0, Ack = 0.
  - CycleCt and Timeout clear to 0 on every ARMED cycle.
  - Start = 0 moves to RUN on the next edge.
  - ARMED lasts as long as Start is held; there is no minimum or maximum.
- RUN:
  - Outputs: PcInit = 0, Busy = 1, PcEn = ~Halt (combinational).
  - The halt instruction itself does not advance the PC.
  - CycleCt increments by 1 every RUN cycle, including the halt cycle. It saturates at all-ones and never wraps.
  - Halt = 1 moves to DONE and sets Ack = 1 on the same edge.
  - Start = 1 aborts the run and moves to ARMED. Start has priority over Halt when both are 1.
- DONE:
  - Outputs: Ack = 1, PcEn = 0, PcInit = 0, Busy = 0.
  - CycleCt is frozen.
  - Halt is ignored.
  - Start = 1 moves to ARMED; Ack returns to 0 on that edge.
- Ack timing: Ack is a state decode registered with the state. It rises one edge after the halt cycle and stays high until Start is reasserted or Reset goes low.
- Start = 0 in IDLE or DONE: no state change.
- Halt outside RUN: no effect.
- Illegal state encoding: go to IDLE on the next edge.

Optional Feature:
- Macro: RUN_WATCHDOG_EN.
- Defined:
  - In RUN, when CycleCt == MAX_CYCLES-1 and Halt = 0 and Start = 0, the next edge moves to DONE with Ack = 1 and Timeout = 1.
  - Timeout holds until ARMED or reset.
  - Halt on that same cycle takes precedence: DONE with Timeout = 0.
- Not defined:
  - No watchdog; RUN persists until Halt, Start or reset.
  - Timeout is tied to 0 and MAX_CYCLES is unused.

Test Plan:
- Reset sequence: Reset = 0 at t = 0, Start = 1, release Reset after 2 cycles -> IDLE then ARMED, PcInit = 1, PcEn = 0, Ack = 0, CycleCt = 0.
- Normal run: Start falls, Halt pulses on the 10th RUN cycle -> PcEn = 1 for 9 cycles and 0 on the halt cycle; Ack = 1 one edge later; CycleCt = 10, frozen while Ack is held for 5 cycles.
- Relaunch from DONE: in DONE raise Start for 3 cycles, then drop it; Halt after 4 cycles -> Ack drops on the first Start edge, CycleCt clears to 0 and ends at 4.
- Abort and priority: in RUN at CycleCt = 6, drive Start = 1 and Halt = 1 in the same cycle -> ARMED, Ack stays 0, CycleCt = 0.
- Async reset mid-run: drive Reset low between edges at CycleCt = 20 -> CycleCt = 0, PcEn = 0 and Busy = 0 immediately, without waiting for a clock edge.
- Watchdog, with RUN_WATCHDOG_EN and MAX_CYCLES = 8, and Halt never asserted -> Ack = 1 and Timeout = 1 after 8 RUN cycles, CycleCt = 8. Without the macro: Ack stays 0 and CycleCt saturates at 16'hFFFF.
